// File: rtl/vram_write_arbiter.sv
// Write-port owner for the 256x256 RGB video RAM: arbitrates user pixel writes
// against a rectangle fill engine, one registered write per cycle at most.
//
// state | meaning
// IDLE  | waiting for fill_start; only the CPU can write
// CLIP  | extents computed from latched rectangle; first pixel may be granted
// FILL  | walking x then y over the clipped rectangle
// DONE  | one-cycle fill_done pulse
module vram_write_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 24,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_data,
  output logic              cpu_ack,
  input  logic              fill_start,
  input  logic [7:0]        fill_x0,
  input  logic [7:0]        fill_y0,
  input  logic [8:0]        fill_w,
  input  logic [8:0]        fill_h,
  input  logic [DATA_W-1:0] fill_color,
  output logic              fill_busy,
  output logic              fill_done,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [DATA_W-1:0] vram_din,
  output logic              vram_we
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CLIP = 2'd1;
  localparam logic [1:0] S_FILL = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic GRANT_CPU  = 1'b0;
  localparam logic GRANT_FILL = 1'b1;

  localparam logic [9:0] LINE_END = 10'(LINE_W);

  logic [1:0]        state, state_nx;
  logic              last_grant;
  logic [7:0]        x0_q, y0_q, x_q, y_q;
  logic [8:0]        w_q, h_q;
  logic [DATA_W-1:0] color_q;
  logic              fill_last;

  logic [9:0]        sum_x, sum_y, xe, ye;
  logic              x_at_end, y_at_end;
  logic              fill_empty;
  logic              fill_el, cpu_el;
  logic              grant_cpu, grant_fill;
  logic [ADDR_W-1:0] fill_addr;

  // 10-bit sums so x0+w never wraps before clipping to the line length
  assign sum_x = {2'b00, x0_q} + {1'b0, w_q};
  assign sum_y = {2'b00, y0_q} + {1'b0, h_q};
  assign xe    = (sum_x > LINE_END) ? LINE_END : sum_x;
  assign ye    = (sum_y > LINE_END) ? LINE_END : sum_y;

  assign x_at_end   = (({2'b00, x_q} + 10'd1) == xe);
  assign y_at_end   = (({2'b00, y_q} + 10'd1) == ye);
  assign fill_empty = (w_q == 9'd0) || (h_q == 9'd0);
  assign fill_addr  = ADDR_W'({y_q, x_q});

  // The first pixel is offered from CLIP so write k lands in cycle 2+k.
  assign fill_el = ((state == S_CLIP) && !fill_empty) ||
                   ((state == S_FILL) && !fill_last);
  // The cycle right after an ack is a forced gap for registered requesters.
  assign cpu_el  = cpu_req && !cpu_ack;

  assign grant_fill = fill_el && (!cpu_el || (last_grant == GRANT_CPU));
  assign grant_cpu  = cpu_el  && (!fill_el || (last_grant == GRANT_FILL));

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (fill_start) state_nx = S_CLIP;
      S_CLIP:  state_nx = fill_empty ? S_DONE : S_FILL;
      S_FILL:  if (fill_last) state_nx = S_DONE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      last_grant <= GRANT_CPU;
      x0_q       <= '0;
      y0_q       <= '0;
      w_q        <= '0;
      h_q        <= '0;
      color_q    <= '0;
      x_q        <= '0;
      y_q        <= '0;
      fill_last  <= 1'b0;
      cpu_ack    <= 1'b0;
      fill_busy  <= 1'b0;
      fill_done  <= 1'b0;
      vram_addr  <= '0;
      vram_din   <= '0;
      vram_we    <= 1'b0;
    end else begin
      state     <= state_nx;
      fill_busy <= (state_nx != S_IDLE);
      fill_done <= (state_nx == S_DONE);
      cpu_ack   <= grant_cpu;
      vram_we   <= grant_cpu | grant_fill;

      if (grant_cpu) begin
        vram_addr  <= cpu_addr;
        vram_din   <= cpu_data;
        last_grant <= GRANT_CPU;
      end else if (grant_fill) begin
        vram_addr  <= fill_addr;
        vram_din   <= color_q;
        last_grant <= GRANT_FILL;
      end

      if ((state == S_IDLE) && fill_start) begin
        x0_q      <= fill_x0;
        y0_q      <= fill_y0;
        w_q       <= fill_w;
        h_q       <= fill_h;
        color_q   <= fill_color;
        x_q       <= fill_x0;
        y_q       <= fill_y0;
        fill_last <= 1'b0;
      end else if (grant_fill) begin
        if (x_at_end) begin
          x_q <= x0_q;
          if (y_at_end) fill_last <= 1'b1;
          else          y_q       <= y_q + 8'd1;
        end else begin
          x_q <= x_q + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vram_write_arbiter.sv
// Directed bench for vram_write_arbiter: CPU writes, fills, clipping,
// contention and mid-fill reset, with hand-computed expected values.
module tb_vram_write_arbiter;

  logic        clk;
  logic        reset;
  logic        cpu_req;
  logic [15:0] cpu_addr;
  logic [23:0] cpu_data;
  logic        cpu_ack;
  logic        fill_start;
  logic [7:0]  fill_x0;
  logic [7:0]  fill_y0;
  logic [8:0]  fill_w;
  logic [8:0]  fill_h;
  logic [23:0] fill_color;
  logic        fill_busy;
  logic        fill_done;
  logic [15:0] vram_addr;
  logic [23:0] vram_din;
  logic        vram_we;

  int vectors;
  int miscompares;

  vram_write_arbiter #(.ADDR_W(16), .DATA_W(24), .LINE_W(256)) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_addr   (cpu_addr),
    .cpu_data   (cpu_data),
    .cpu_ack    (cpu_ack),
    .fill_start (fill_start),
    .fill_x0    (fill_x0),
    .fill_y0    (fill_y0),
    .fill_w     (fill_w),
    .fill_h     (fill_h),
    .fill_color (fill_color),
    .fill_busy  (fill_busy),
    .fill_done  (fill_done),
    .vram_addr  (vram_addr),
    .vram_din   (vram_din),
    .vram_we    (vram_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance into the next cycle; outputs are stable 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_we"},   {31'd0, vram_we},   32'd0);
    chk({tag, "_busy"}, {31'd0, fill_busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, fill_done}, 32'd0);
  endtask

  task automatic chk_wr(input string tag, input logic [15:0] a, input logic [23:0] d, input logic ack);
    chk({tag, "_we"},   {31'd0, vram_we},   32'd1);
    chk({tag, "_addr"}, {16'd0, vram_addr}, {16'd0, a});
    chk({tag, "_din"},  {8'd0, vram_din},   {8'd0, d});
    chk({tag, "_ack"},  {31'd0, cpu_ack},   {31'd0, ack});
  endtask

  task automatic start_fill(input logic [7:0] x0, input logic [7:0] y0,
                            input logic [8:0] w, input logic [8:0] h, input logic [23:0] c);
    fill_x0 = x0; fill_y0 = y0; fill_w = w; fill_h = h; fill_color = c;
    fill_start = 1'b1;
  endtask

  initial begin
    logic [15:0] a5 [0:9];
    logic        c5 [0:9];

    vectors = 0;
    miscompares = 0;
    reset = 1'b1;
    cpu_req = 1'b0; cpu_addr = '0; cpu_data = '0;
    fill_start = 1'b0; fill_x0 = '0; fill_y0 = '0; fill_w = '0; fill_h = '0; fill_color = '0;

    tick(); tick();
    chk_idle("rst");
    chk("rst_ack",  {31'd0, cpu_ack}, 32'd0);
    chk("rst_addr", {16'd0, vram_addr}, 32'd0);
    chk("rst_din",  {8'd0, vram_din}, 32'd0);
    reset = 1'b0;
    tick();

    // 1: single CPU write, request held through the ack cycle
    cpu_req = 1'b1; cpu_addr = 16'h1234; cpu_data = 24'hFF0000;
    chk("t1_c0_we", {31'd0, vram_we}, 32'd0);
    tick();
    chk_wr("t1_c1", 16'h1234, 24'hFF0000, 1'b1);
    tick();
    chk("t1_c2_we",  {31'd0, vram_we}, 32'd0);
    chk("t1_c2_ack", {31'd0, cpu_ack}, 32'd0);
    cpu_req = 1'b0;
    tick();
    chk("t1_c3_we", {31'd0, vram_we}, 32'd0);

    // 2: 2x2 fill at (10,20)
    start_fill(8'd10, 8'd20, 9'd2, 9'd2, 24'h00FF00);
    tick();
    fill_start = 1'b0;
    chk("t2_c1_busy", {31'd0, fill_busy}, 32'd1);
    chk("t2_c1_we",   {31'd0, vram_we}, 32'd0);
    tick(); chk_wr("t2_c2", 16'h140A, 24'h00FF00, 1'b0);
    tick(); chk_wr("t2_c3", 16'h140B, 24'h00FF00, 1'b0);
    tick(); chk_wr("t2_c4", 16'h150A, 24'h00FF00, 1'b0);
    tick(); chk_wr("t2_c5", 16'h150B, 24'h00FF00, 1'b0);
    chk("t2_c5_done", {31'd0, fill_done}, 32'd0);
    tick();
    chk("t2_c6_done", {31'd0, fill_done}, 32'd1);
    chk("t2_c6_busy", {31'd0, fill_busy}, 32'd1);
    chk("t2_c6_we",   {31'd0, vram_we}, 32'd0);
    tick();
    chk_idle("t2_c7");
    chk("t2_c7_hold", {16'd0, vram_addr}, 32'h150B);

    // 3: fill clipped at the bottom-right corner
    start_fill(8'd250, 8'd255, 9'd10, 9'd4, 24'h0000FF);
    tick();
    fill_start = 1'b0;
    chk("t3_c1_we", {31'd0, vram_we}, 32'd0);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk_wr($sformatf("t3_w%0d", k), 16'hFFFA + 16'(k), 24'h0000FF, 1'b0);
    end
    tick();
    chk("t3_c8_done", {31'd0, fill_done}, 32'd1);
    chk("t3_c8_we",   {31'd0, vram_we}, 32'd0);
    tick();
    chk_idle("t3_c9");

    // 4: zero-width fill
    start_fill(8'd3, 8'd4, 9'd0, 9'd5, 24'h777777);
    tick();
    fill_start = 1'b0;
    chk("t4_c1_busy", {31'd0, fill_busy}, 32'd1);
    chk("t4_c1_done", {31'd0, fill_done}, 32'd0);
    chk("t4_c1_we",   {31'd0, vram_we}, 32'd0);
    tick();
    chk("t4_c2_busy", {31'd0, fill_busy}, 32'd1);
    chk("t4_c2_done", {31'd0, fill_done}, 32'd1);
    chk("t4_c2_we",   {31'd0, vram_we}, 32'd0);
    tick();
    chk_idle("t4_c3");

    // 5: 4x1 fill with CPU request held permanently (last grant was fill)
    a5[0] = 16'h0000; c5[0] = 1'b0;
    a5[1] = 16'hABCD; c5[1] = 1'b1;
    a5[2] = 16'h3264; c5[2] = 1'b0;
    a5[3] = 16'hABCD; c5[3] = 1'b1;
    a5[4] = 16'h3265; c5[4] = 1'b0;
    a5[5] = 16'hABCD; c5[5] = 1'b1;
    a5[6] = 16'h3266; c5[6] = 1'b0;
    a5[7] = 16'hABCD; c5[7] = 1'b1;
    a5[8] = 16'h3267; c5[8] = 1'b0;
    a5[9] = 16'hABCD; c5[9] = 1'b1;
    start_fill(8'd100, 8'd50, 9'd4, 9'd1, 24'hA5A5A5);
    cpu_req = 1'b1; cpu_addr = 16'hABCD; cpu_data = 24'h123456;
    tick();
    fill_start = 1'b0;
    for (int t = 1; t < 10; t++) begin
      chk_wr($sformatf("t5_c%0d", t), a5[t], c5[t] ? 24'h123456 : 24'hA5A5A5, c5[t]);
      chk($sformatf("t5_c%0d_done", t), {31'd0, fill_done}, (t == 9) ? 32'd1 : 32'd0);
      tick();
    end
    cpu_req = 1'b0;
    chk_idle("t5_c10");

    // 6: reset in cycle 3 of an 8-pixel fill
    tick();
    start_fill(8'd0, 8'd0, 9'd8, 9'd1, 24'h010203);
    tick();
    fill_start = 1'b0;
    tick(); chk_wr("t6_c2", 16'h0000, 24'h010203, 1'b0);
    tick(); chk_wr("t6_c3", 16'h0001, 24'h010203, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_idle("t6_c4");
    chk("t6_c4_addr", {16'd0, vram_addr}, 32'd0);
    for (int t = 5; t < 10; t++) begin
      tick();
      chk_idle($sformatf("t6_c%0d", t));
    end
    start_fill(8'd5, 8'd6, 9'd1, 9'd1, 24'hCAFE00);
    tick();
    fill_start = 1'b0;
    chk("t6r_c1_busy", {31'd0, fill_busy}, 32'd1);
    tick(); chk_wr("t6r_c2", 16'h0605, 24'hCAFE00, 1'b0);
    tick();
    chk("t6r_c3_done", {31'd0, fill_done}, 32'd1);
    chk("t6r_c3_we",   {31'd0, vram_we}, 32'd0);
    tick();
    chk_idle("t6r_c4");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
